systolic_feeder: RTL and testbench

- Upstream operand feeder for the 3x3 MAC systolic array. It holds matrix A (3x3) and matrix B (3x3) of 8-bit custom floats: sign[7], exp[6:4] bias 3, frac[3:0]. 8'h00 means zero.
- On start it streams A rows into the left edge of the array and B columns into the top edge, diagonally skewed. Padding is 8'h00.
- It then waits for the array to drain and pulses done.
- It does no arithmetic; the MAC cells consume its outputs one cycle per hop.

---
 rtl/systolic_feeder.sv | 137 +++++++++++++
 tb/tb_systolic_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for a 3x3 systolic MAC array: streams A rows left and B columns top, diagonally skewed.
// All outputs registered; a run takes 9 cycles from the start edge, and loads/starts are ignored while busy.
module systolic_feeder #(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_en,
   input  logic       load_sel,
   input  logic [1:0] load_row,
   input  logic [1:0] load_col,
   input  logic [7:0] load_data,
   input  logic       start,
   output logic [7:0] a0,
   output logic [7:0] a1,
   output logic [7:0] a2,
   output logic [7:0] b0,
   output logic [7:0] b1,
   output logic [7:0] b2,
   output logic       busy,
   output logic       done
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [2:0]      r_k;
   logic [2:0]      w_k_nx;
   logic [DW-1:0]   r_drain;
   logic [DW-1:0]   w_drain_nx;
   logic [7:0]      r_ma [0:2][0:2];
   logic [7:0]      r_mb [0:2][0:2];
   logic [7:0]      w_ma_nx [0:2][0:2];
   logic [7:0]      w_mb_nx [0:2][0:2];
   logic [7:0]      r_aout [0:2];
   logic [7:0]      r_bout [0:2];
   logic [7:0]      w_aout_nx [0:2];
   logic [7:0]      w_bout_nx [0:2];
   logic            r_busy;
   logic            r_done;
   logic            w_wr;
   logic [2:0]      w_d;

   // Post-write view of the matrices, so a load on the start edge feeds step 0.
   always_comb begin
      w_wr    = (r_state == S_IDLE) && load_en && (load_row != 2'd3) && (load_col != 2'd3);
      w_ma_nx = r_ma;
      w_mb_nx = r_mb;
      if (w_wr) begin
         if (load_sel) w_mb_nx[load_row][load_col] = load_data;
         else          w_ma_nx[load_row][load_col] = load_data;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_k_nx     = r_k;
      w_drain_nx = r_drain;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nx = S_STREAM;
               w_k_nx     = 3'd0;
            end
         end
         S_STREAM: begin
            if (r_k == 3'd4) begin
               w_state_nx = S_DRAIN;
               w_drain_nx = '0;
            end else begin
               w_k_nx = r_k + 3'd1;
            end
         end
         S_DRAIN: begin
            if (r_drain == DW'(DRAIN_CYCLES - 1)) w_state_nx = S_DONE;
            else                                  w_drain_nx = r_drain + DW'(1);
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Row i / column j lags the stream by i / j steps.
   always_comb begin
      w_d = '0;
      for (int i = 0; i < 3; i++) begin
         w_aout_nx[i] = 8'h00;
         w_bout_nx[i] = 8'h00;
         w_d          = w_k_nx - 3'(i);
         if ((w_state_nx == S_STREAM) && (w_k_nx >= 3'(i)) && (w_d <= 3'd2)) begin
            w_aout_nx[i] = w_ma_nx[i][w_d[1:0]];
            w_bout_nx[i] = w_mb_nx[w_d[1:0]][i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_k     <= 3'd0;
         r_drain <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_aout[i] <= 8'h00;
            r_bout[i] <= 8'h00;
            for (int j = 0; j < 3; j++) begin
               r_ma[i][j] <= 8'h00;
               r_mb[i][j] <= 8'h00;
            end
         end
      end else begin
         r_state <= w_state_nx;
         r_k     <= w_k_nx;
         r_drain <= w_drain_nx;
         r_busy  <= (w_state_nx == S_STREAM) || (w_state_nx == S_DRAIN);
         r_done  <= (w_state_nx == S_DONE);
         r_aout  <= w_aout_nx;
         r_bout  <= w_bout_nx;
         r_ma    <= w_ma_nx;
         r_mb    <= w_mb_nx;
      end
   end

   assign a0   = r_aout[0];
   assign a1   = r_aout[1];
   assign a2   = r_aout[2];
   assign b0   = r_bout[0];
   assign b1   = r_bout[1];
   assign b2   = r_bout[2];
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: spec-level stream model plus a real-valued systolic product check.
module tb_systolic_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_en;
   logic       load_sel;
   logic [1:0] load_row;
   logic [1:0] load_col;
   logic [7:0] load_data;
   logic       start;
   logic [7:0] a0, a1, a2, b0, b1, b2;
   logic       busy, done;

   int errors = 0;
   int checks = 0;

   logic [7:0] ma [3][3];
   logic [7:0] mb [3][3];
   logic [7:0] ca [3][10];
   logic [7:0] cb [3][10];

   systolic_feeder #(.DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel),
      .load_row(load_row), .load_col(load_col), .load_data(load_data), .start(start),
      .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Value of an 8-bit custom float: sign[7], exponent[6:4] bias 3, fraction[3:0].
   function automatic real fval(input logic [7:0] x);
      real m;
      if (x == 8'h00) return 0.0;
      m = 1.0 + real'(x[3:0]) / 16.0;
      for (int n = 0; n < int'(x[6:4]); n++) m = m * 2.0;
      m = m / 8.0;
      if (x[7]) m = -m;
      return m;
   endfunction

   // Edge operands at step k: row i carries A[i][k-i], column j carries B[k-j][j].
   function automatic logic [47:0] exp_ops(input int k);
      logic [7:0] ea [3];
      logic [7:0] eb [3];
      for (int i = 0; i < 3; i++) begin
         ea[i] = 8'h00;
         eb[i] = 8'h00;
         if (k >= 0 && k <= 4 && k - i >= 0 && k - i <= 2) begin
            ea[i] = ma[i][k-i];
            eb[i] = mb[k-i][i];
         end
      end
      return {ea[0], ea[1], ea[2], eb[0], eb[1], eb[2]};
   endfunction

   function automatic logic [49:0] observed();
      return {a0, a1, a2, b0, b1, b2, busy, done};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            ma[i][j] = 8'h00;
            mb[i][j] = 8'h00;
         end
   endtask

   task automatic load(input bit sel, input int r, input int c, input logic [7:0] d);
      @(negedge clk);
      load_en = 1'b1; load_sel = sel; load_row = 2'(r); load_col = 2'(c); load_data = d;
      @(posedge clk); #1;
      load_en = 1'b0;
      if (r < 3 && c < 3) begin
         if (sel) mb[r][c] = d;
         else     ma[r][c] = d;
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            load(1'b0, i, j, 8'($urandom));
            load(1'b1, i, j, 8'($urandom));
         end
   endtask

   // One full run from a start pulse. Optionally writes one element on the start edge,
   // and optionally holds start + a write to A[0][0] over cycles inj_lo..inj_hi.
   task automatic run_stream(input string name, input int inj_lo, input int inj_hi,
                             input bit ld, input bit ld_sel, input int ld_r, input int ld_c,
                             input logic [7:0] ld_d);
      logic [49:0] exp_v;
      logic [49:0] obs_v;
      real got, want;
      bit  bad;
      @(negedge clk);
      start = 1'b1;
      if (ld) begin
         load_en = 1'b1; load_sel = ld_sel; load_row = 2'(ld_r); load_col = 2'(ld_c); load_data = ld_d;
         if (ld_r < 3 && ld_c < 3) begin
            if (ld_sel) mb[ld_r][ld_c] = ld_d;
            else        ma[ld_r][ld_c] = ld_d;
         end
      end
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         obs_v = observed();
         exp_v = {exp_ops(c), (c <= 7), (c == 8)};
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got ops/busy/done %h, want %h", name, c, obs_v, exp_v);
         end
         if (c < 10) begin
            ca[0][c] = a0; ca[1][c] = a1; ca[2][c] = a2;
            cb[0][c] = b0; cb[1][c] = b1; cb[2][c] = b2;
         end
         if (c == inj_lo) begin
            start = 1'b1; load_en = 1'b1; load_sel = 1'b0; load_row = 2'd0; load_col = 2'd0;
            load_data = 8'h7F;
         end
         if (c == inj_hi) begin start = 1'b0; load_en = 1'b0; end
      end
      // Operands hop one cell per cycle; cell (i,j) accumulates a_i(t-j)*b_j(t-i).
      bad = 1'b0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            got = 0.0; want = 0.0;
            for (int t = 0; t < 10; t++)
               if (t - j >= 0 && t - i >= 0) got = got + fval(ca[i][t-j]) * fval(cb[j][t-i]);
            for (int k = 0; k < 3; k++) want = want + fval(ma[i][k]) * fval(mb[k][j]);
            if (got != want && !bad) begin
               bad = 1'b1;
               $display("FAIL %s array_product C[%0d][%0d]: got %f, want %f", name, i, j, got, want);
            end
         end
      checks++;
      if (bad) errors++;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (observed() !== 50'd0) begin
         errors++;
         $display("FAIL reset_initial: got %h, want 0", observed());
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_skew_stream();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            load(1'b0, i, j, 8'(8'h31 + 3*i + j));
            load(1'b1, i, j, 8'(8'hB1 + 3*i + j));
         end
      run_stream("skew", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_lockout();
      run_stream("lockout", 1, 9, 1'b0, 1'b0, 0, 0, 8'h00);
      checks++;
      if (observed() !== 50'd0) begin
         errors++;
         $display("FAIL lockout_no_restart: got %h, want 0", observed());
      end
      run_stream("lockout_rerun", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_bad_index();
      load(1'b0, 3, 1, 8'h55);
      load(1'b1, 2, 3, 8'h55);
      load(1'b0, 3, 3, 8'h55);
      run_stream("bad_index", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_load_start_same_edge();
      run_stream("load_on_start_a", -1, -1, 1'b1, 1'b0, 0, 0, 8'($urandom));
      run_stream("load_on_start_b", -1, -1, 1'b1, 1'b1, 0, 0, 8'($urandom));
   endtask

   task automatic test_random_streams();
      for (int n = 0; n < 3; n++) begin
         load_random();
         run_stream("random", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
         run_stream("random_rerun", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
      end
   endtask

   task automatic test_mid_run_reset();
      load_random();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      clear_model();
      checks++;
      if (observed() !== 50'd0) begin
         errors++;
         $display("FAIL mid_run_reset_async: got %h, want 0", observed());
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset_no_done cycle %0d: got busy=%b done=%b, want 0 0", c, busy, done);
         end
      end
      run_stream("after_mid_reset", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_reset_random();
      for (int n = 0; n < 3; n++) begin
         load_random();
         @(negedge clk); start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
         repeat ($urandom_range(0, 9)) @(posedge clk);
         #2;
         rst = 1'b1;
         #1;
         clear_model();
         checks++;
         if (observed() !== 50'd0) begin
            errors++;
            $display("FAIL reset_random %0d: got %h, want 0", n, observed());
         end
         @(negedge clk); rst = 1'b0;
      end
      run_stream("after_random_reset", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
   endtask

   task automatic test_identity();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            load(1'b0, i, j, (i == j) ? 8'h30 : 8'h00);
            load(1'b1, i, j, (i == j) ? 8'h30 : 8'h00);
         end
      run_stream("identity", -1, -1, 1'b0, 1'b0, 0, 0, 8'h00);
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_row = 2'd0; load_col = 2'd0;
      load_data = 8'h00; start = 1'b0;
      clear_model();
      test_reset();
      test_skew_stream();
      test_lockout();
      test_bad_index();
      test_load_start_same_edge();
      test_random_streams();
      test_mid_run_reset();
      test_reset_random();
      test_identity();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
